// File: rtl/math_sub_fab_if.sv
// math_sub_fab_if: operand/result bundle for the fabric subtractor
interface math_sub_fab_if #(
  parameter int WIDTH = 16
);
  logic ena, vld_in, vld_out, ovf;
  logic [WIDTH-1:0] dina, dinb, dout;
  modport master(output ena, vld_in, dina, dinb, input vld_out, dout, ovf);
  modport slave(input ena, vld_in, dina, dinb, output vld_out, dout, ovf);
endinterface

// File: rtl/math_sub_fab.sv
// math_sub_fab: fabric-sliced pipelined signed subtractor with valid tracking and overflow flag
// Define MATH_SUB_FAB_SAT_EN to clamp dout on overflow instead of wrapping.
module math_sub_fab #(
  parameter int WIDTH = 16,
  parameter int LATENCY = 1
) (
  input logic clk,
  input logic rst,
  math_sub_fab_if.slave io
);
  localparam int NUM_STAGES = LATENCY + 1;
  localparam int NS = LATENCY;
  localparam int SLICE = WIDTH / NUM_STAGES;
  logic [WIDTH-1:0] dw;
  logic sa, sb;
  if (WIDTH % NUM_STAGES != 0) begin : g_chk
    $fatal(1, "math_sub_fab: WIDTH must be a multiple of LATENCY+1");
  end
  for (genvar n = 0; n < NUM_STAGES; n++) begin : g_s
    logic [2*SLICE-1:0] op;
    logic [SLICE-1:0] a, b, d;
    logic bin;
    assign a = op[2*SLICE-1:SLICE];
    assign b = op[SLICE-1:0];
    if (n == 0) begin : g_i
      assign op = {io.dina[0 +: SLICE], io.dinb[0 +: SLICE]};
      assign bin = 1'b0;
    end else begin : g_i
      logic [n:1][2*SLICE-1:0] sk;
      always_ff @(posedge clk or negedge rst)
        if (!rst) sk <= '0;
        else if (io.ena) begin
          sk[1] <= {io.dina[n*SLICE +: SLICE], io.dinb[n*SLICE +: SLICE]};
          for (int i = 2; i <= n; i++) sk[i] <= sk[i-1];
        end
      assign op = sk[n];
      assign bin = g_s[n-1].g_b.bq;
    end
    if (n < NS) begin : g_b
      logic bo, bq;
      logic [NS-n:1][SLICE-1:0] dq;
      assign {bo, d} = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          bq <= 1'b0;
          dq <= '0;
        end else if (io.ena) begin
          bq <= bo;
          dq[1] <= d;
          for (int i = 2; i <= NS - n; i++) dq[i] <= dq[i-1];
        end
      assign dw[n*SLICE +: SLICE] = dq[NS-n];
    end else begin : g_t
      // top slice feeds dout directly, so its signs are aligned with the result
      assign d = a - b - SLICE'(bin);
      assign dw[n*SLICE +: SLICE] = d;
      assign sa = a[SLICE-1];
      assign sb = b[SLICE-1];
    end
  end
  if (LATENCY == 0) begin : g_v
    assign io.vld_out = io.vld_in;
  end else begin : g_v
    logic [LATENCY-1:0] vq;
    always_ff @(posedge clk or negedge rst)
      if (!rst) vq <= '0;
      else if (io.ena) vq <= LATENCY'({vq, io.vld_in});
    assign io.vld_out = vq[LATENCY-1];
  end
  assign io.ovf = (sa != sb) && (dw[WIDTH-1] != sa);
`ifdef MATH_SUB_FAB_SAT_EN
  assign io.dout = io.ovf ? {sa, {(WIDTH-1){~sa}}} : dw;
`else
  assign io.dout = dw;
`endif
endmodule

// File: tb/tb_math_sub_fab.sv
// tb_math_sub_fab: directed and randomized checks of math_sub_fab at (16,1) and (32,3)
module tb_math_sub_fab;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  math_sub_fab_if #(.WIDTH(16)) io1();
  math_sub_fab_if #(.WIDTH(32)) io3();
  math_sub_fab #(.WIDTH(16), .LATENCY(1)) dut1(.clk(clk), .rst(rst), .io(io1));
  math_sub_fab #(.WIDTH(32), .LATENCY(3)) dut3(.clk(clk), .rst(rst), .io(io3));
  typedef struct packed {logic v; logic o; logic [31:0] d;} exp_t;
  exp_t q1[$];
  exp_t q3[$];
`ifdef MATH_SUB_FAB_SAT_EN
  localparam logic [15:0] OV_NEG = 16'h8000;
  localparam logic [15:0] OV_POS = 16'h7FFF;
`else
  localparam logic [15:0] OV_NEG = 16'h7FFF;
  localparam logic [15:0] OV_POS = 16'h8000;
`endif

  function automatic longint sx(input logic [31:0] x, input int w);
    return longint'($signed(x << (32 - w))) >>> (32 - w);
  endfunction

  function automatic exp_t model(input logic v, input longint a, input longint b, input int w);
    longint lim = longint'(1) << (w - 1);
    longint d = a - b;
    exp_t e;
    e.v = v;
    e.o = (d >= lim) || (d < -lim);
`ifdef MATH_SUB_FAB_SAT_EN
    if (e.o) d = (d < 0) ? -lim : lim - 1;
`endif
    e.d = 32'(d) & 32'((longint'(1) << w) - 1);
    return e;
  endfunction

  task automatic test_reset();
    io1.ena = 1'b1; io1.vld_in = 1'b1; io1.dina = 16'h1234; io1.dinb = 16'h0F0F;
    io3.ena = 1'b1; io3.vld_in = 1'b1; io3.dina = 32'h1234_5678; io3.dinb = 32'h0101_0101;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (io1.dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0000", io1.dout); end
    total++; if (io1.vld_out !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", io1.vld_out); end
    total++; if (io1.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", io1.ovf); end
    total++; if (io3.dout !== 32'h0) begin bad++; $display("FAIL reset_dout3 got=%h exp=0", io3.dout); end
    total++; if (io3.vld_out !== 1'b0) begin bad++; $display("FAIL reset_vld3 got=%b exp=0", io3.vld_out); end
    io1.vld_in = 1'b0;
    io3.vld_in = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      total++; if (io1.vld_out !== 1'b0) begin bad++; $display("FAIL post_reset_vld got=%b exp=0", io1.vld_out); end
      total++; if (io3.vld_out !== 1'b0) begin bad++; $display("FAIL post_reset_vld3 got=%b exp=0", io3.vld_out); end
    end
  endtask

  task automatic test_borrow();
    io1.dina = 16'h0100; io1.dinb = 16'h0001; io1.vld_in = 1'b1;
    @(posedge clk); #1;
    io1.vld_in = 1'b0;
    total++; if (io1.dout !== 16'h00FF) begin bad++; $display("FAIL borrow_dout got=%h exp=00ff", io1.dout); end
    total++; if (io1.vld_out !== 1'b1) begin bad++; $display("FAIL borrow_vld got=%b exp=1", io1.vld_out); end
    total++; if (io1.ovf !== 1'b0) begin bad++; $display("FAIL borrow_ovf got=%b exp=0", io1.ovf); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a [3] = '{16'd5, 16'd0, 16'h1234};
    logic [15:0] b [3] = '{16'd3, 16'd1, 16'h0234};
    logic [15:0] r [3] = '{16'h0002, 16'hFFFF, 16'h1000};
    for (int i = 0; i < 3; i++) begin
      io1.dina = a[i]; io1.dinb = b[i]; io1.vld_in = 1'b1;
      @(posedge clk); #1;
      total++; if (io1.dout !== r[i]) begin bad++; $display("FAIL b2b_dout[%0d] got=%h exp=%h", i, io1.dout, r[i]); end
      total++; if (io1.vld_out !== 1'b1) begin bad++; $display("FAIL b2b_vld[%0d] got=%b exp=1", i, io1.vld_out); end
    end
    io1.vld_in = 1'b0;
    @(posedge clk); #1;
    total++; if (io1.vld_out !== 1'b0) begin bad++; $display("FAIL b2b_tail_vld got=%b exp=0", io1.vld_out); end
  endtask

  task automatic test_stall();
    io1.dina = 16'd5; io1.dinb = 16'd3; io1.vld_in = 1'b1;
    @(posedge clk); #1;
    io1.dina = 16'd0; io1.dinb = 16'd1; io1.ena = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (io1.dout !== 16'h0002) begin bad++; $display("FAIL stall_dout got=%h exp=0002", io1.dout); end
      total++; if (io1.vld_out !== 1'b1) begin bad++; $display("FAIL stall_vld got=%b exp=1", io1.vld_out); end
    end
    io1.ena = 1'b1;
    @(posedge clk); #1;
    total++; if (io1.dout !== 16'hFFFF) begin bad++; $display("FAIL stall_r1 got=%h exp=ffff", io1.dout); end
    io1.dina = 16'h1234; io1.dinb = 16'h0234;
    @(posedge clk); #1;
    total++; if (io1.dout !== 16'h1000) begin bad++; $display("FAIL stall_r2 got=%h exp=1000", io1.dout); end
    io1.vld_in = 1'b0;
    @(posedge clk); #1;
    total++; if (io1.vld_out !== 1'b0) begin bad++; $display("FAIL stall_tail_vld got=%b exp=0", io1.vld_out); end
  endtask

  task automatic test_overflow();
    logic [15:0] a [3] = '{16'h8000, 16'h7FFF, 16'hFFFF};
    logic [15:0] b [3] = '{16'h0001, 16'hFFFF, 16'h0001};
    logic [15:0] r [3] = '{OV_NEG, OV_POS, 16'hFFFE};
    logic o [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      io1.dina = a[i]; io1.dinb = b[i]; io1.vld_in = 1'b1;
      @(posedge clk); #1;
      total++; if (io1.dout !== r[i]) begin bad++; $display("FAIL ovf_dout[%0d] got=%h exp=%h", i, io1.dout, r[i]); end
      total++; if (io1.ovf !== o[i]) begin bad++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, io1.ovf, o[i]); end
    end
    io1.vld_in = 1'b0;
  endtask

  task automatic test_lat3();
    io3.dina = 32'h0001_0000; io3.dinb = 32'h0000_0001; io3.vld_in = 1'b1;
    @(posedge clk); #1;
    io3.dina = 32'h0; io3.dinb = 32'h0; io3.vld_in = 1'b0;
    repeat (2) begin
      total++; if (io3.vld_out !== 1'b0) begin bad++; $display("FAIL lat3_early_vld got=%b exp=0", io3.vld_out); end
      @(posedge clk); #1;
    end
    total++; if (io3.dout !== 32'h0000_FFFF) begin bad++; $display("FAIL lat3_dout got=%h exp=0000ffff", io3.dout); end
    total++; if (io3.vld_out !== 1'b1) begin bad++; $display("FAIL lat3_vld got=%b exp=1", io3.vld_out); end
    @(posedge clk); #1;
    total++; if (io3.vld_out !== 1'b0) begin bad++; $display("FAIL lat3_tail_vld got=%b exp=0", io3.vld_out); end
  endtask

  task automatic test_random();
    logic [15:0] a1, b1;
    logic [31:0] a3, b3;
    logic e1, e3, v1, v3;
    q1.delete();
    q3.delete();
    for (int k = 0; k < 10000; k++) begin
      a1 = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      a3 = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
      b3 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      e1 = ($urandom_range(0, 4) != 0);
      e3 = ($urandom_range(0, 4) != 0);
      v1 = 1'($urandom);
      v3 = 1'($urandom);
      io1.dina = a1; io1.dinb = b1; io1.ena = e1; io1.vld_in = v1;
      io3.dina = a3; io3.dinb = b3; io3.ena = e3; io3.vld_in = v3;
      @(posedge clk); #1;
      if (e1) begin
        q1.push_back(model(v1, sx(32'(a1), 16), sx(32'(b1), 16), 16));
        if (q1.size() > 1) void'(q1.pop_front());
      end
      if (e3) begin
        q3.push_back(model(v3, sx(a3, 32), sx(b3, 32), 32));
        if (q3.size() > 3) void'(q3.pop_front());
      end
      if (q1.size() == 1) begin
        total++; if (io1.dout !== q1[0].d[15:0]) begin bad++; $display("FAIL rnd1_dout k=%0d got=%h exp=%h", k, io1.dout, q1[0].d[15:0]); end
        total++; if (io1.ovf !== q1[0].o) begin bad++; $display("FAIL rnd1_ovf k=%0d got=%b exp=%b", k, io1.ovf, q1[0].o); end
        total++; if (io1.vld_out !== q1[0].v) begin bad++; $display("FAIL rnd1_vld k=%0d got=%b exp=%b", k, io1.vld_out, q1[0].v); end
      end
      if (q3.size() == 3) begin
        total++; if (io3.dout !== q3[0].d) begin bad++; $display("FAIL rnd3_dout k=%0d got=%h exp=%h", k, io3.dout, q3[0].d); end
        total++; if (io3.ovf !== q3[0].o) begin bad++; $display("FAIL rnd3_ovf k=%0d got=%b exp=%b", k, io3.ovf, q3[0].o); end
        total++; if (io3.vld_out !== q3[0].v) begin bad++; $display("FAIL rnd3_vld k=%0d got=%b exp=%b", k, io3.vld_out, q3[0].v); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_lat3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
